mdu: RTL
========

Name: mdu

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Next-generation arithmetic block beside the ALU in the datapath: the ALU remains single-cycle; this unit adds mult/multu/div/divu/mthi/mtlo.
- Fixed, parametrised latency. Busy/start handshake so the hazard unit can stall mfhi/mflo and dependent MDU ops.
- Synchronous flush cancels an in-flight operation on exception/interrupt.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
flush  input  1  synchronous cancel of in-flight operation
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
SrcA  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
SrcB  input  WIDTH  rt operand (divisor / multiplier)
Start  output  1  combinational: MDUOp in 1..4 this cycle and accepted
Busy  output  1  registered: operation in flight (counter != 0)
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
Reset and flush:
- reset: HI=0, LO=0, counter=0, pending result cleared, Busy=0.
- Priority: reset > flush > op.

Acceptance:
- An op is accepted only when Busy=0 and flush=0.
- Ops presented while Busy=1 are ignored; the hazard unit stalls on Start|Busy, so this is a protection path only.
- Start = (MDUOp in 1..4) & !Busy & !flush.

Mult/div accepted at edge ending cycle k:
- Result is computed from the SrcA/SrcB values at that edge and held in internal pending registers.
- Counter loads MULT_CYCLES or DIV_CYCLES.
- Busy is high in cycles k+1 .. k+N.
- At the edge where counter==1: HI/LO are written from the pending registers and counter goes to 0.
- New HI/LO are visible from cycle k+N+1.

mthi/mtlo accepted at edge ending cycle k:
- HI (resp. LO) takes SrcA, visible from cycle k+1.
- Busy is not raised.

Arithmetic:
- mult: signed 2W-bit product. multu: unsigned 2W-bit product. HI=upper W bits, LO=lower W bits.
- div: signed; quotient truncates toward zero; remainder takes the sign of the dividend. LO=quotient, HI=remainder.
- divu: unsigned. LO=quotient, HI=remainder.
- Divide by zero (div or divu): LO = all ones, HI = SrcA. Deterministic; no exception.
- Signed overflow (SrcA = -2^(W-1), SrcB = -1): LO = -2^(W-1), HI = 0.

flush:
- Clears counter to 0 and discards the pending result; HI/LO keep their old values.
- Busy falls the next cycle.
- An op presented in the same cycle as flush is dropped, including mthi/mtlo.
- flush on the exact cycle counter==1: the result is discarded (flush wins).

Other boundaries:
- Back-to-back: a new op may be accepted in cycle k+N+1, the first cycle with Busy=0.
- reset mid-operation behaves as flush and also clears HI/LO to 0.
- Reads of HI/LO while Busy=1 return the old values; stalling is the hazard unit's responsibility.

Decomposition:
- Shared package mdu_pkg holds:
  - MDUOp encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - Width constant for MDUOp (3).
- The Controller uses the same package constants.
- One sub-module, mdu_arith: purely combinational. Takes op, SrcA, SrcB; produces hi_next and lo_next, including the divide-by-zero and overflow rules.
- The mdu top holds the counter, pending registers, HI/LO and the acceptance logic.

Test Plan:
- reset held 2 cycles, then MDUOp=1 (mult), SrcA=0xFFFFFFFE (-2), SrcB=3 -> Start=1 in that cycle; Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MDUOp=2 (multu), SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- MDUOp=3 (div), SrcA=-7, SrcB=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide-by-zero and overflow:
  - div with SrcA=0x12345678, SrcB=0 -> LO=0xFFFFFFFF, HI=0x12345678.
  - div with SrcA=0x80000000, SrcB=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start divu 100/7, then present mthi SrcA=0xAA on cycle 3 of Busy, then assert flush on cycle 6:
  - mthi is ignored.
  - Busy drops the cycle after flush.
  - HI/LO keep their pre-divu values.
  - A following mtlo 0x55 is accepted next cycle: LO=0x55 one cycle later.
- Back-to-back: mult 6*7, then divu 42/5 in the first cycle with Busy=0 -> LO=42 visible exactly when Busy falls; the second op is accepted that cycle; finally LO=8, HI=2 after 10 more busy cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared MDUOp encodings for the multiply/divide unit and the
//                controller that drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational multiply/divide datapath producing the next
//                HI/LO pair, including divide-by-zero and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_hi_next,
  output logic [WIDTH-1:0] o_lo_next
);

  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_sq_mag;
  logic [WIDTH-1:0]   w_sr_mag;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic               w_div_zero;
  logic               w_overflow;

  // Sign-extending to 2W bits makes the modular product equal the signed one.
  assign w_prod_s = {{WIDTH{i_src_a[WIDTH-1]}}, i_src_a} *
                    {{WIDTH{i_src_b[WIDTH-1]}}, i_src_b};
  assign w_prod_u = {{WIDTH{1'b0}}, i_src_a} * {{WIDTH{1'b0}}, i_src_b};

  // Signed divide works on magnitudes; the sign fix-up gives truncation
  // toward zero and a remainder carrying the dividend's sign.
  assign w_neg_a  = i_src_a[WIDTH-1];
  assign w_neg_b  = i_src_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -i_src_a : i_src_a;
  assign w_abs_b  = w_neg_b ? -i_src_b : i_src_b;
  assign w_sq_mag = w_abs_a / w_abs_b;
  assign w_sr_mag = w_abs_a % w_abs_b;
  assign w_uq     = i_src_a / i_src_b;
  assign w_ur     = i_src_a % i_src_b;

  assign w_div_zero = (i_src_b == '0);
  assign w_overflow = (i_src_a == C_MIN_NEG) && (i_src_b == '1);

  // Select the HI/LO pair for the requested operation.
  always_comb begin
    o_hi_next = '0;
    o_lo_next = '0;
    case (i_op)
      MDU_MULT:  {o_hi_next, o_lo_next} = w_prod_s;
      MDU_MULTU: {o_hi_next, o_lo_next} = w_prod_u;
      MDU_DIV: begin
        if (w_div_zero) begin
          o_lo_next = '1;
          o_hi_next = i_src_a;
        end else if (w_overflow) begin
          o_lo_next = C_MIN_NEG;
          o_hi_next = '0;
        end else begin
          o_lo_next = (w_neg_a ^ w_neg_b) ? -w_sq_mag : w_sq_mag;
          o_hi_next = w_neg_a ? -w_sr_mag : w_sr_mag;
        end
      end
      MDU_DIVU: begin
        if (w_div_zero) begin
          o_lo_next = '1;
          o_hi_next = i_src_a;
        end else begin
          o_lo_next = w_uq;
          o_hi_next = w_ur;
        end
      end
      default: begin
        o_hi_next = '0;
        o_lo_next = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multi-cycle multiply/divide unit with HI/LO registers,
//                fixed latency, busy/start handshake and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [MDU_OP_W-1:0] MDUOp,
  input  logic [WIDTH-1:0]    SrcA,
  input  logic [WIDTH-1:0]    SrcB,
  output logic                Start,
  output logic                Busy,
  output logic [WIDTH-1:0]    HI,
  output logic [WIDTH-1:0]    LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  mdu_op_e          w_op;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign w_op = mdu_op_e'(MDUOp);

  mdu_arith #(
    .WIDTH     (WIDTH)
  ) u_arith (
    .i_op      (w_op),
    .i_src_a   (SrcA),
    .i_src_b   (SrcB),
    .o_hi_next (w_hi_next),
    .o_lo_next (w_lo_next)
  );

  assign Busy  = (r_cnt != '0);
  assign Start = is_long_op(w_op) && !Busy && !flush;
  assign HI    = r_hi;
  assign LO    = r_lo;

  // Counter, pending result and HI/LO; reset beats flush beats a new op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (flush) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (r_cnt != '0) begin
      // Ops arriving while busy are ignored; commit on the final busy cycle.
      if (r_cnt == C_ONE) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      r_cnt <= r_cnt - C_ONE;
    end else begin
      case (w_op)
        MDU_MULT, MDU_MULTU: begin
          r_pend_hi <= w_hi_next;
          r_pend_lo <= w_lo_next;
          r_cnt     <= C_MULT_LOAD;
        end
        MDU_DIV, MDU_DIVU: begin
          r_pend_hi <= w_hi_next;
          r_pend_lo <= w_lo_next;
          r_cnt     <= C_DIV_LOAD;
        end
        MDU_MTHI: r_hi <= SrcA;
        MDU_MTLO: r_lo <= SrcA;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
